// File: rtl/cc_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cc_serializer
// Description : Parallel-in/serial-out stage placed after the 8-bit 2:1 data
//               mux. A word is captured on a load request while idle, then
//               shifted out one bit per enabled cycle. A one-cycle done pulse
//               follows the last bit, and ready returns on the next cycle.
//
// Ports       : CC_SERIALIZER_CLOCK_50     - system clock, rising edge
//               CC_SERIALIZER_RESET_InHigh - synchronous reset, active-high
//               CC_SERIALIZER_data_InBUS   - parallel word from the mux
//               CC_SERIALIZER_load_In      - load request, honoured when ready
//               CC_SERIALIZER_enable_In    - consumer shift strobe
//               CC_SERIALIZER_ready_Out    - idle, a load is accepted now
//               CC_SERIALIZER_valid_Out    - serial_Out holds a live bit
//               CC_SERIALIZER_serial_Out   - current serial bit
//               CC_SERIALIZER_done_Out     - pulse after last bit consumed
//
// Revision    : 1.0 - initial release
// ============================================================================
module cc_serializer #(
    parameter int SERIALIZER_DATAWIDTH = 8,
    parameter bit SERIALIZER_LSBFIRST  = 1'b0
) (
    input  logic                            CC_SERIALIZER_CLOCK_50,
    input  logic                            CC_SERIALIZER_RESET_InHigh,
    input  logic [SERIALIZER_DATAWIDTH-1:0] CC_SERIALIZER_data_InBUS,
    input  logic                            CC_SERIALIZER_load_In,
    input  logic                            CC_SERIALIZER_enable_In,
    output logic                            CC_SERIALIZER_ready_Out,
    output logic                            CC_SERIALIZER_valid_Out,
    output logic                            CC_SERIALIZER_serial_Out,
    output logic                            CC_SERIALIZER_done_Out
);

    localparam int                c_CNTW = $clog2(SERIALIZER_DATAWIDTH);
    localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(SERIALIZER_DATAWIDTH - 1);
    localparam logic [c_CNTW-1:0] c_ONE  = c_CNTW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [SERIALIZER_DATAWIDTH-1:0] shreg_q, shreg_d;
    logic [c_CNTW-1:0]               cnt_q,   cnt_d;

    // Shift direction and output tap depend only on the bit order, so they
    // are selected at elaboration time.
    logic [SERIALIZER_DATAWIDTH-1:0] w_shifted;
    logic                            w_outbit;

    generate
        if (SERIALIZER_LSBFIRST) begin : g_lsb_first
            assign w_shifted = {1'b0, shreg_q[SERIALIZER_DATAWIDTH-1:1]};
            assign w_outbit  = shreg_q[0];
        end else begin : g_msb_first
            assign w_shifted = {shreg_q[SERIALIZER_DATAWIDTH-2:0], 1'b0};
            assign w_outbit  = shreg_q[SERIALIZER_DATAWIDTH-1];
        end
    endgenerate

    always_ff @(posedge CC_SERIALIZER_CLOCK_50) begin
        if (CC_SERIALIZER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (CC_SERIALIZER_load_In) begin
                    shreg_d = CC_SERIALIZER_data_InBUS;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (CC_SERIALIZER_enable_In) begin
                    // The last bit is consumed without shifting; the register
                    // content no longer matters once DONE is reached.
                    if (cnt_q == c_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        shreg_d = w_shifted;
                        cnt_d   = cnt_q + c_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs are pure decodes of registered state.
    assign CC_SERIALIZER_ready_Out  = (state_q == ST_IDLE);
    assign CC_SERIALIZER_valid_Out  = (state_q == ST_SHIFT);
    assign CC_SERIALIZER_done_Out   = (state_q == ST_DONE);
    assign CC_SERIALIZER_serial_Out = (state_q == ST_SHIFT) && w_outbit;

endmodule
`default_nettype wire

// File: tb/tb_cc_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_serializer
// Description : Bench for cc_serializer. Two instances (MSB-first and
//               LSB-first) share one stimulus stream. A word/bit-index model
//               predicts every output each cycle; directed sequences add
//               literal expectations before a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_serializer;

    localparam int W = 8;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         load = 1'b0;
    logic         en   = 1'b0;
    logic [W-1:0] data = '0;

    wire rdy_m, vld_m, ser_m, dn_m;
    wire rdy_l, vld_l, ser_l, dn_l;

    int  total  = 0;
    int  bad    = 0;
    int  cyc    = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    cc_serializer #(.SERIALIZER_DATAWIDTH(W), .SERIALIZER_LSBFIRST(1'b0)) u_msb (
        .CC_SERIALIZER_CLOCK_50    (clk),
        .CC_SERIALIZER_RESET_InHigh(rst),
        .CC_SERIALIZER_data_InBUS  (data),
        .CC_SERIALIZER_load_In     (load),
        .CC_SERIALIZER_enable_In   (en),
        .CC_SERIALIZER_ready_Out   (rdy_m),
        .CC_SERIALIZER_valid_Out   (vld_m),
        .CC_SERIALIZER_serial_Out  (ser_m),
        .CC_SERIALIZER_done_Out    (dn_m)
    );

    cc_serializer #(.SERIALIZER_DATAWIDTH(W), .SERIALIZER_LSBFIRST(1'b1)) u_lsb (
        .CC_SERIALIZER_CLOCK_50    (clk),
        .CC_SERIALIZER_RESET_InHigh(rst),
        .CC_SERIALIZER_data_InBUS  (data),
        .CC_SERIALIZER_load_In     (load),
        .CC_SERIALIZER_enable_In   (en),
        .CC_SERIALIZER_ready_Out   (rdy_l),
        .CC_SERIALIZER_valid_Out   (vld_l),
        .CC_SERIALIZER_serial_Out  (ser_l),
        .CC_SERIALIZER_done_Out    (dn_l)
    );

    // ------------------------------------------------------------------
    // Reference model: a word, how many of its bits have been consumed,
    // and which phase of the handshake we are in (0 idle, 1 busy, 2 done).
    // ------------------------------------------------------------------
    int           m_phase = 0;
    int           m_idx   = 0;
    logic [W-1:0] m_word  = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_phase <= 0;
            m_idx   <= 0;
            m_word  <= '0;
        end else if (m_phase == 0) begin
            if (load) begin
                m_word  <= data;
                m_idx   <= 0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (en) begin
                if (m_idx == W - 1) m_phase <= 2;
                else                m_idx   <= m_idx + 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Single compare process against the model, once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready",  rdy_m, m_phase == 0);
            check("m_valid",  vld_m, m_phase == 1);
            check("m_done",   dn_m,  m_phase == 2);
            check("m_serial", ser_m, (m_phase == 1) ? m_word[W-1-m_idx] : 1'b0);
            check("l_ready",  rdy_l, m_phase == 0);
            check("l_valid",  vld_l, m_phase == 1);
            check("l_done",   dn_l,  m_phase == 2);
            check("l_serial", ser_l, (m_phase == 1) ? m_word[m_idx] : 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] exp1;
        logic [7:0] exp5;
        int         prev;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_ready",  rdy_m, 1'b1);
        check("rst_valid",  vld_m, 1'b0);
        check("rst_serial", ser_m, 1'b0);
        check("rst_done",   dn_m,  1'b0);
        chk_en = 1'b1;
        rst    = 1'b0;
        tick();

        // MSB-first 0xA5 with continuous enable
        exp1 = 8'hA5;
        data = 8'hA5; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0; data = 8'h00;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("t1_valid", vld_m, 1'b1);
            check("t1_bit",   ser_m, exp1[7-i]);
            tick();
        end
        @(negedge clk);
        check("t1_done",       dn_m,  1'b1);
        check("t1_done_valid", vld_m, 1'b0);
        tick();
        @(negedge clk);
        check("t1_ready",     rdy_m, 1'b1);
        check("t1_done_gone", dn_m,  1'b0);

        // 0x01 seen by both bit orders
        exp5 = 8'h01;
        data = 8'h01; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("t5_lsb_bit", ser_l, exp5[i]);
            check("t5_msb_bit", ser_m, exp5[7-i]);
            tick();
        end
        @(negedge clk);
        check("t5_lsb_done", dn_l, 1'b1);
        tick();

        // Reset after three bits of 0x80 have been consumed
        data = 8'h80; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t4_ready", rdy_m, 1'b1);
        check("t4_valid", vld_m, 1'b0);
        check("t4_done",  dn_m,  1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t4_no_done", dn_m, 1'b0);
        end
        tick();
        data = 8'h01; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (12) tick();

        // Loads while busy are ignored
        data = 8'h0F; load = 1'b1;
        tick();
        load = 1'b0; data = 8'hFF;
        tick();
        load = 1'b1; tick();
        load = 1'b0; tick();
        load = 1'b1; tick();
        load = 1'b0;
        repeat (10) tick();

        // Stalled enable on 0xC3
        data = 8'hC3; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            tick();
        end
        en = 1'b1;
        repeat (3) tick();

        // Back-to-back words, mux select toggles while done is up
        data = 8'h55; load = 1'b1; en = 1'b1;
        prev = -1;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (dn_m) data = ~data;
            if (rdy_m) begin
                if (prev >= 0) check_int("t6_period", cyc - prev, W + 2);
                prev = cyc;
            end
            @(posedge clk);
        end
        #2;
        load = 1'b0;
        repeat (12) tick();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 9) < 7);
            data = W'($urandom);
            tick();
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
